axi_sub_rr_arb: RTL and testbench
=================================

Name: axi_sub_rr_arb

Overview:
N-way round-robin arbiter sharing one component interface (register block or SRAM) between N AXI subordinate request ports, each carrying both reads and writes.
- Locks the grant for a whole burst and keeps it stable across component holds.
- Routes write errors back to the granted requester in the same cycle.
- Tracks the owner of each accepted read through a C_LAT-deep pipeline, so rdata and rd_err return to the correct requester.

Parameters:
N, 4, number of requester ports (2..16)
NW, $clog2(N), requester index width (derived; do not override)
AW, 32, byte address width
DW, 32, data width
BC, DW/8, byte-strobe count (derived)
UW, 32, user width
IW, 1, AXI ID width
C_LAT, 1, component latency in cycles from accepted read (dv && !hld) to rdata/rd_err; 0..8

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_dv  in  N  per-requester beat valid
req_write  in  N  1 = write beat
req_addr  in  N*AW  byte address; slice i = [i*AW +: AW]
req_user  in  N*UW  user sideband
req_id  in  N*IW  AXI ID
req_wdata  in  N*DW  write data
req_wstrb  in  N*BC  write strobes
req_size  in  N*3  AXI size
req_last  in  N  final beat of burst
req_hld  out  N  per-requester hold
req_err  out  N  error: write err same cycle; read err with req_rvalid
req_rvalid  out  N  one-hot read-data return strobe
req_rdata  out  DW  read data, broadcast to all requesters
dv, write, addr, user, id, wdata, wstrb, size, last  out  1/1/AW/UW/IW/DW/BC/3/1  muxed component request
hld  in  1  component stall
rd_err  in  1  read error, aligned with rdata
wr_err  in  1  write error, aligned with accepted write beat
rdata  in  DW  component read data

Behaviour:
- State: ptr_q[NW] (round-robin pointer), gnt_q[NW], lock_q, pipeline of C_LAT stages {vld, own[NW]}. All of these reset to 0 asynchronously.
- Winner selection:
  - When lock_q=1: winner = gnt_q.
  - Otherwise: winner = first i with req_dv[i], scanning ptr_q, ptr_q+1, ... and wrapping modulo N.
  - No request pending: dv=0, all req_hld=1, muxed fields = requester 0 slice.
- Outputs:
  - dv = req_dv[winner] (a locked winner that drops dv yields dv=0).
  - Muxed fields come from the winner slice.
  - req_hld[i] = hld || (i != winner) || !req_dv[i].
  - accept = dv && !hld.
- Lock:
  - Set lock_q=1, gnt_q=winner when dv && (hld || !last), i.e. stalled beat or mid-burst.
  - Clear lock_q when accept && last.
  - Grant is stable from first presentation until the last beat is accepted; no other requester is accepted in between.
- Pointer: on accept && last, ptr_q <= winner+1 modulo N (N not a power of 2: wraps from N-1 to 0). Otherwise ptr_q holds.
- Write errors: req_err[winner] = wr_err when accept && write, in the same cycle.
- Read return, C_LAT=0:
  - req_rvalid[winner] = accept && !write, same cycle.
  - req_err[winner] = rd_err on that beat.
- Read return, C_LAT>0:
  - Stage 0 loads {accept && !write, winner} every cycle; stages shift unconditionally.
  - The last stage drives req_rvalid[own] = vld and req_err[own] |= rd_err && vld.
  - The component pipeline does not stall on hld for already-accepted reads.
- Simultaneous events: a write-error beat and a read return in the same cycle to the same requester OR into req_err. A bench must not expect them to be separable; requesters distinguish the two by req_rvalid.
- req_rdata = rdata, unregistered.
- Reset mid-burst: lock, pointer and pipeline are cleared; in-flight reads produce no req_rvalid.
- Assertions:
  - At most one bit of (req_dv & ~req_hld) set per cycle.
  - req_rvalid is one-hot-or-zero.
  - gnt_q < N.

Test Plan:
1. N=4, all requesters send single-beat reads every cycle, hld=0 -> grants 0,1,2,3,0,... one per cycle; with C_LAT=1, req_rvalid one-hot follows one cycle later in the same order.
2. Req1 issues a 4-beat write burst while req0/req2 request; hld asserted on beat 2 for 3 cycles -> dv held with req1 fields, req0/req2 hld=1 throughout; after req1's last beat, grant goes to req2 (ptr=2).
3. Wrap: ptr_q=3, requests on 0 and 3 only -> 3 wins; next arbitration 0 wins; ptr_q returns to 0 after it.
4. C_LAT=2, reads from req0 then req3 in back-to-back cycles, rd_err=1 on the second return -> req_rvalid[0] at t+2, req_rvalid[3] and req_err[3] at t+3, req_err[0]=0.
5. Write beat with wr_err=1 from req2 -> req_err[2]=1 in the same cycle only; no req_rvalid.
6. Assert rst_n=0 mid-burst with 2 reads in flight -> lock_q=0, ptr_q=0, no req_rvalid after release; first request after reset arbitrates from index 0.

Source files
------------

// File: rtl/axi_sub_rr_arb_if.sv
// Bundle of the requester-side and component-side signals around axi_sub_rr_arb.
// The arbiter takes the slave view; a driver or bench takes the master view.
interface axi_sub_rr_arb_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned UW = 32,
  parameter int unsigned IW = 1
);
  localparam int unsigned BC = DW / 8;

  logic [N-1:0]    req_dv;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*UW-1:0] req_user;
  logic [N*IW-1:0] req_id;
  logic [N*DW-1:0] req_wdata;
  logic [N*BC-1:0] req_wstrb;
  logic [N*3-1:0]  req_size;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_hld;
  logic [N-1:0]    req_err;
  logic [N-1:0]    req_rvalid;
  logic [DW-1:0]   req_rdata;

  logic            dv;
  logic            write;
  logic [AW-1:0]   addr;
  logic [UW-1:0]   user;
  logic [IW-1:0]   id;
  logic [DW-1:0]   wdata;
  logic [BC-1:0]   wstrb;
  logic [2:0]      size;
  logic            last;
  logic            hld;
  logic            rd_err;
  logic            wr_err;
  logic [DW-1:0]   rdata;

  modport slave (
    input  req_dv, req_write, req_addr, req_user, req_id, req_wdata, req_wstrb, req_size,
    input  req_last, hld, rd_err, wr_err, rdata,
    output req_hld, req_err, req_rvalid, req_rdata,
    output dv, write, addr, user, id, wdata, wstrb, size, last
  );

  modport master (
    output req_dv, req_write, req_addr, req_user, req_id, req_wdata, req_wstrb, req_size,
    output req_last, hld, rd_err, wr_err, rdata,
    input  req_hld, req_err, req_rvalid, req_rdata,
    input  dv, write, addr, user, id, wdata, wstrb, size, last
  );
endinterface

// File: rtl/axi_sub_rr_arb.sv
// Round-robin arbiter sharing one register/SRAM component port between N AXI requesters.
// Grants lock for a whole burst; read returns follow a C_LAT-deep owner pipeline.
module axi_sub_rr_arb #(
  parameter int unsigned N     = 4,
  parameter int unsigned NW    = $clog2(N),
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned BC    = DW / 8,
  parameter int unsigned UW    = 32,
  parameter int unsigned IW    = 1,
  parameter int unsigned C_LAT = 1
) (
  input logic             clk,
  input logic             rst_n,
  axi_sub_rr_arb_if.slave bus
);
  logic [NW-1:0] ptr_q, ptr_d, gnt_q, gnt_d;
  logic [NW-1:0] scan_win, winner, rv_own;
  logic [NW:0]   idx;
  logic          lock_q, lock_d, found, accept, rv_vld;

  // First requester at or after ptr_q, wrapping modulo N.
  always_comb begin
    scan_win = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_q} + (NW+1)'(k);
      if (idx >= (NW+1)'(N)) idx = idx - (NW+1)'(N);
      if (!found && bus.req_dv[idx[NW-1:0]]) begin
        found    = 1'b1;
        scan_win = idx[NW-1:0];
      end
    end
  end

  assign winner = lock_q ? gnt_q : scan_win;

  assign bus.dv    = bus.req_dv[winner];
  assign bus.write = bus.req_write[winner];
  assign bus.addr  = bus.req_addr[winner*AW +: AW];
  assign bus.user  = bus.req_user[winner*UW +: UW];
  assign bus.id    = bus.req_id[winner*IW +: IW];
  assign bus.wdata = bus.req_wdata[winner*DW +: DW];
  assign bus.wstrb = bus.req_wstrb[winner*BC +: BC];
  assign bus.size  = bus.req_size[winner*3 +: 3];
  assign bus.last  = bus.req_last[winner];

  assign accept        = bus.dv && !bus.hld;
  assign bus.req_rdata = bus.rdata;

  always_comb begin
    bus.req_hld = '1;
    for (int i = 0; i < N; i++) begin
      bus.req_hld[i] = bus.hld || (NW'(i) != winner) || !bus.req_dv[i];
    end
  end

  always_comb begin
    lock_d = lock_q;
    gnt_d  = gnt_q;
    ptr_d  = ptr_q;
    if (accept && bus.last) begin
      lock_d = 1'b0;
      ptr_d  = (winner == NW'(N - 1)) ? '0 : winner + NW'(1);
    end else if (bus.dv && (bus.hld || !bus.last)) begin
      lock_d = 1'b1;
      gnt_d  = winner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      gnt_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      gnt_q  <= gnt_d;
      lock_q <= lock_d;
    end
  end

  if (C_LAT == 0) begin : g_lat0
    assign rv_vld = accept && !bus.write;
    assign rv_own = winner;
  end else begin : g_pipe
    logic [C_LAT-1:0] vld_q;
    logic [NW-1:0]    own_q [C_LAT];

    // Shifts regardless of hld: accepted reads are already committed in the component.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= '0;
        for (int s = 0; s < C_LAT; s++) own_q[s] <= '0;
      end else begin
        vld_q[0] <= accept && !bus.write;
        own_q[0] <= winner;
        for (int s = 1; s < C_LAT; s++) begin
          vld_q[s] <= vld_q[s-1];
          own_q[s] <= own_q[s-1];
        end
      end
    end

    assign rv_vld = vld_q[C_LAT-1];
    assign rv_own = own_q[C_LAT-1];
  end

  always_comb begin
    bus.req_err    = '0;
    bus.req_rvalid = '0;
    if (accept && bus.write) bus.req_err[winner] = bus.wr_err;
    if (rv_vld) begin
      bus.req_rvalid[rv_own] = 1'b1;
      bus.req_err[rv_own]    = bus.req_err[rv_own] | bus.rd_err;
    end
  end

  a_one_grant: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.req_dv & ~bus.req_hld));
  a_rvalid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.req_rvalid));
  a_gnt_range: assert property (@(posedge clk) disable iff (!rst_n)
    {1'b0, gnt_q} < (NW+1)'(N));
endmodule

// File: tb/tb_axi_sub_rr_arb.sv
// Directed bench for axi_sub_rr_arb: three instances (C_LAT 0, 1, 2) share one stimulus stream
// so return timing can be compared across latencies.
module tb_axi_sub_rr_arb;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  axi_sub_rr_arb_if #(.N(N)) b0 ();
  axi_sub_rr_arb_if #(.N(N)) b1 ();
  axi_sub_rr_arb_if #(.N(N)) b2 ();

  axi_sub_rr_arb #(.N(N), .C_LAT(0)) u_lat0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  axi_sub_rr_arb #(.N(N), .C_LAT(1)) u_lat1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  axi_sub_rr_arb #(.N(N), .C_LAT(2)) u_lat2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  assign b0.req_dv    = b1.req_dv;     assign b2.req_dv    = b1.req_dv;
  assign b0.req_write = b1.req_write;  assign b2.req_write = b1.req_write;
  assign b0.req_addr  = b1.req_addr;   assign b2.req_addr  = b1.req_addr;
  assign b0.req_user  = b1.req_user;   assign b2.req_user  = b1.req_user;
  assign b0.req_id    = b1.req_id;     assign b2.req_id    = b1.req_id;
  assign b0.req_wdata = b1.req_wdata;  assign b2.req_wdata = b1.req_wdata;
  assign b0.req_wstrb = b1.req_wstrb;  assign b2.req_wstrb = b1.req_wstrb;
  assign b0.req_size  = b1.req_size;   assign b2.req_size  = b1.req_size;
  assign b0.req_last  = b1.req_last;   assign b2.req_last  = b1.req_last;
  assign b0.hld       = b1.hld;        assign b2.hld       = b1.hld;
  assign b0.rd_err    = b1.rd_err;     assign b2.rd_err    = b1.rd_err;
  assign b0.wr_err    = b1.wr_err;     assign b2.wr_err    = b1.wr_err;
  assign b0.rdata     = b1.rdata;      assign b2.rdata     = b1.rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic dv, input logic wr, input logic last,
                         input logic [31:0] wd);
    b1.req_dv[i]             = dv;
    b1.req_write[i]          = wr;
    b1.req_last[i]           = last;
    b1.req_wdata[i*32 +: 32] = wd;
  endtask

  task automatic clr();
    b1.req_dv    = '0;
    b1.req_write = '0;
    b1.req_last  = '0;
  endtask

  initial begin
    logic [63:0] e;
    rst_n     = 1'b0;
    clr();
    b1.hld    = 1'b0;
    b1.rd_err = 1'b0;
    b1.wr_err = 1'b0;
    b1.rdata  = 32'hC0DE_F00D;
    for (int i = 0; i < N; i++) begin
      b1.req_addr[i*32 +: 32]  = 32'h100 * (i + 1);
      b1.req_user[i*32 +: 32]  = 32'h55 + i;
      b1.req_id[i]             = 1'(i % 2);
      b1.req_wstrb[i*4 +: 4]   = 4'(1 << i);
      b1.req_size[i*3 +: 3]    = 3'(i);
      b1.req_wdata[i*32 +: 32] = '0;
    end

    // Reset / idle state
    smp();
    chk("rst_dv", 64'(b1.dv), 0);
    chk("rst_hld", 64'(b1.req_hld), 'hF);
    chk("rst_rvalid", 64'(b1.req_rvalid), 0);
    chk("rst_err", 64'(b1.req_err), 0);
    chk("idle_addr", 64'(b1.addr), 'h100);
    chk("rdata_pass", 64'(b1.req_rdata), 'hC0DEF00D);
    nxt();
    rst_n = 1'b1;

    // 1: all four requesters issue single-beat reads every cycle
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 1'b1, 32'h0);
    for (int k = 0; k < 5; k++) begin
      smp();
      e = 64'('hF & ~(1 << (k % 4)));
      chk("t1_hld", 64'(b1.req_hld), e);
      chk("t1_addr", 64'(b1.addr), 64'('h100 * (k % 4 + 1)));
      chk("t1_rv_lat0", 64'(b0.req_rvalid), 64'(1 << (k % 4)));
      e = (k >= 1) ? 64'(1 << ((k - 1) % 4)) : 64'(0);
      chk("t1_rv_lat1", 64'(b1.req_rvalid), e);
      e = (k >= 2) ? 64'(1 << ((k - 2) % 4)) : 64'(0);
      chk("t1_rv_lat2", 64'(b2.req_rvalid), e);
      nxt();
    end
    clr();
    smp();
    chk("t1_tail_lat1", 64'(b1.req_rvalid), 'h1);
    chk("t1_tail_lat2", 64'(b2.req_rvalid), 'h8);
    nxt();
    smp();
    chk("t1_tail2_lat2", 64'(b2.req_rvalid), 'h1);
    nxt();

    // 2: req1 4-beat write burst with req0/req2 competing; pointer now 1
    set_req(0, 1'b1, 1'b0, 1'b1, 32'h0);
    set_req(2, 1'b1, 1'b0, 1'b1, 32'h0);
    set_req(1, 1'b1, 1'b1, 1'b0, 32'hA0);
    smp();
    chk("t2_w0_hld", 64'(b1.req_hld), 'hD);
    chk("t2_w0_dv", 64'(b1.dv), 1);
    chk("t2_w0_write", 64'(b1.write), 1);
    chk("t2_w0_wdata", 64'(b1.wdata), 'hA0);
    chk("t2_w0_wstrb", 64'(b1.wstrb), 'h2);
    chk("t2_w0_size", 64'(b1.size), 1);
    chk("t2_w0_user", 64'(b1.user), 'h56);
    chk("t2_w0_id", 64'(b1.id), 1);
    chk("t2_w0_norv", 64'(b0.req_rvalid), 0);
    nxt();
    set_req(1, 1'b1, 1'b1, 1'b0, 32'hA1);
    smp();
    chk("t2_w1_hld", 64'(b1.req_hld), 'hD);
    chk("t2_w1_wdata", 64'(b1.wdata), 'hA1);
    nxt();
    set_req(1, 1'b0, 1'b1, 1'b0, 32'hA1);
    smp();
    chk("t2_bubble_dv", 64'(b1.dv), 0);
    chk("t2_bubble_hld", 64'(b1.req_hld), 'hF);
    nxt();
    set_req(1, 1'b1, 1'b1, 1'b0, 32'hA2);
    b1.hld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("t2_stall_dv", 64'(b1.dv), 1);
      chk("t2_stall_hld", 64'(b1.req_hld), 'hF);
      chk("t2_stall_wdata", 64'(b1.wdata), 'hA2);
      chk("t2_stall_addr", 64'(b1.addr), 'h200);
      nxt();
    end
    b1.hld = 1'b0;
    smp();
    chk("t2_w2_hld", 64'(b1.req_hld), 'hD);
    nxt();
    set_req(1, 1'b1, 1'b1, 1'b1, 32'hA3);
    smp();
    chk("t2_w3_hld", 64'(b1.req_hld), 'hD);
    chk("t2_w3_wdata", 64'(b1.wdata), 'hA3);
    nxt();
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0);
    smp();
    chk("t2_next_hld", 64'(b1.req_hld), 'hB);
    chk("t2_next_addr", 64'(b1.addr), 'h300);
    nxt();

    // 3: pointer at 3, requests on 0 and 3 only
    set_req(2, 1'b0, 1'b0, 1'b0, 32'h0);
    set_req(3, 1'b1, 1'b0, 1'b1, 32'h0);
    smp();
    chk("t3_p3_hld", 64'(b1.req_hld), 'h7);
    nxt();
    smp();
    chk("t3_wrap_hld", 64'(b1.req_hld), 'hE);
    nxt();
    smp();
    chk("t3_again_hld", 64'(b1.req_hld), 'h7);
    nxt();
    clr();
    nxt();
    nxt();

    // 5: write error from req2 returns in the same cycle only
    set_req(2, 1'b1, 1'b1, 1'b1, 32'hBEEF);
    b1.wr_err = 1'b1;
    smp();
    chk("t5_err_lat1", 64'(b1.req_err), 'h4);
    chk("t5_err_lat0", 64'(b0.req_err), 'h4);
    chk("t5_norv", 64'(b1.req_rvalid), 0);
    nxt();
    set_req(2, 1'b0, 1'b0, 1'b0, 32'h0);
    smp();
    chk("t5_err_gone", 64'(b1.req_err), 0);
    nxt();
    b1.wr_err = 1'b0;

    // 4: back-to-back reads from req0 then req3; rd_err on the second return
    set_req(0, 1'b1, 1'b0, 1'b1, 32'h0);
    smp();
    chk("t4_r0_hld", 64'(b1.req_hld), 'hE);
    nxt();
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0);
    set_req(3, 1'b1, 1'b0, 1'b1, 32'h0);
    smp();
    chk("t4_r3_hld", 64'(b1.req_hld), 'h7);
    chk("t4_lat1_rv0", 64'(b1.req_rvalid), 'h1);
    nxt();
    clr();
    smp();
    chk("t4_lat2_rv0", 64'(b2.req_rvalid), 'h1);
    chk("t4_lat2_err0", 64'(b2.req_err), 0);
    chk("t4_lat1_rv3", 64'(b1.req_rvalid), 'h8);
    nxt();
    b1.rd_err = 1'b1;
    smp();
    chk("t4_lat2_rv3", 64'(b2.req_rvalid), 'h8);
    chk("t4_lat2_err3", 64'(b2.req_err), 'h8);
    chk("t4_lat1_noerr", 64'(b1.req_err), 0);
    chk("t4_lat1_norv", 64'(b1.req_rvalid), 0);
    nxt();
    b1.rd_err = 1'b0;

    // 6: reset during a locked req2 read burst with reads in flight
    set_req(1, 1'b1, 1'b0, 1'b1, 32'h0);
    smp();
    chk("t6_r1_hld", 64'(b1.req_hld), 'hD);
    nxt();
    set_req(1, 1'b0, 1'b0, 1'b0, 32'h0);
    set_req(2, 1'b1, 1'b0, 1'b0, 32'h0);
    smp();
    chk("t6_b0_hld", 64'(b1.req_hld), 'hB);
    nxt();
    set_req(0, 1'b1, 1'b0, 1'b1, 32'h0);
    set_req(1, 1'b1, 1'b0, 1'b1, 32'h0);
    smp();
    chk("t6_b1_lock", 64'(b1.req_hld), 'hB);
    nxt();
    rst_n = 1'b0;
    smp();
    chk("t6_rst_rv1", 64'(b1.req_rvalid), 0);
    chk("t6_rst_rv2", 64'(b2.req_rvalid), 0);
    nxt();
    rst_n = 1'b1;
    set_req(0, 1'b0, 1'b0, 1'b0, 32'h0);
    smp();
    chk("t6_post_hld", 64'(b1.req_hld), 'hD);
    chk("t6_post_rv1", 64'(b1.req_rvalid), 0);
    chk("t6_post_rv2", 64'(b2.req_rvalid), 0);
    chk("t6_post_rv0", 64'(b0.req_rvalid), 'h2);
    nxt();
    clr();
    smp();
    chk("t6_ret_lat1", 64'(b1.req_rvalid), 'h2);
    chk("t6_ret_lat2_early", 64'(b2.req_rvalid), 0);
    nxt();
    smp();
    chk("t6_ret_lat2", 64'(b2.req_rvalid), 'h2);
    nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
